// File: rtl/note_sprite_pkg.sv
// -----------------------------------------------------------------------------
// note_sprite_pkg
// Shared definitions for the note sprite renderer: glyph identifiers, the
// note-head row span table, stem/hollow/flag geometry and a helper that
// answers "is this glyph pixel inked?" for any (glyph, row, col) triple.
// Coordinates are in the unflipped orientation (stem down on the left).
// -----------------------------------------------------------------------------
package note_sprite_pkg;

    typedef enum logic [1:0] {
        GLYPH_QUARTER = 2'd0,
        GLYPH_HALF    = 2'd1,
        GLYPH_WHOLE   = 2'd2,
        GLYPH_EIGHTH  = 2'd3
    } glyph_id_e;

    // Note head: rows 7..14, each row filled from col 1 to HEAD_COL_LAST[row-7].
    localparam int HEAD_ROW_FIRST = 7;
    localparam int HEAD_ROW_LAST  = 14;
    localparam int HEAD_COL_FIRST = 1;
    localparam logic [7:0][4:0] HEAD_COL_LAST = {
        5'd11, 5'd13, 5'd14, 5'd15, 5'd15, 5'd14, 5'd13, 5'd11
    };

    // Hollow centre used by the half and whole notes.
    localparam int HOLLOW_ROW_FIRST = 9;
    localparam int HOLLOW_ROW_LAST  = 12;
    localparam int HOLLOW_COL_FIRST = 4;
    localparam int HOLLOW_COL_LAST  = 11;

    // Stem runs down the left edge from the head to the bottom of the glyph.
    localparam int STEM_COL_FIRST = 0;
    localparam int STEM_COL_LAST  = 1;
    localparam int STEM_ROW_FIRST = 7;
    localparam int STEM_ROW_LAST  = 29;

    // Eighth-note flag: a two-pixel-wide diagonal, pixels (2+k, 20+k) and (3+k, 20+k).
    localparam int FLAG_ROW_FIRST = 20;
    localparam int FLAG_LEN       = 8;
    localparam int FLAG_COL_FIRST = 2;

    function automatic logic glyph_px(input int glyph, input int row, input int col);
        logic head;
        logic hollow;
        logic stem;
        logic flag;
        logic px;
        head = 1'b0;
        if (row >= HEAD_ROW_FIRST && row <= HEAD_ROW_LAST)
            head = (col >= HEAD_COL_FIRST) &&
                   (col <= int'(HEAD_COL_LAST[3'(row - HEAD_ROW_FIRST)]));
        hollow = (row >= HOLLOW_ROW_FIRST) && (row <= HOLLOW_ROW_LAST) &&
                 (col >= HOLLOW_COL_FIRST) && (col <= HOLLOW_COL_LAST);
        stem   = (col >= STEM_COL_FIRST) && (col <= STEM_COL_LAST) &&
                 (row >= STEM_ROW_FIRST) && (row <= STEM_ROW_LAST);
        flag   = (row >= FLAG_ROW_FIRST) && (row < FLAG_ROW_FIRST + FLAG_LEN) &&
                 ((col == FLAG_COL_FIRST + (row - FLAG_ROW_FIRST)) ||
                  (col == FLAG_COL_FIRST + 1 + (row - FLAG_ROW_FIRST)));
        case (glyph)
            int'(GLYPH_QUARTER): px = head | stem;
            int'(GLYPH_HALF):    px = (head & ~hollow) | stem;
            int'(GLYPH_WHOLE):   px = head & ~hollow;
            int'(GLYPH_EIGHTH):  px = head | stem | flag;
            default:             px = 1'b0;
        endcase
        return px;
    endfunction

endpackage

// File: rtl/note_glyph_rom.sv
// -----------------------------------------------------------------------------
// note_glyph_rom
// One-bit-wide glyph bitmap ROM, NUM_GLYPHS*GLYPH_W*GLYPH_H deep, laid out as
// glyph-major, then row-major. The image is a constant built at elaboration
// from the package geometry, so it maps to a ROM/LUT rather than a RAM.
// Slots beyond the four defined glyphs are blank.
//   clk       in   pixel clock
//   addr      in   glyph*W*H + row*W + col
//   pixel_out out  ink bit, registered (one cycle read latency)
// -----------------------------------------------------------------------------
module note_glyph_rom
    import note_sprite_pkg::*;
#(
    parameter int GLYPH_W    = 20,
    parameter int GLYPH_H    = 30,
    parameter int NUM_GLYPHS = 4,
    parameter int ADDR_W     = $clog2(NUM_GLYPHS * GLYPH_W * GLYPH_H)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic              pixel_out
);

    localparam int DEPTH = NUM_GLYPHS * GLYPH_W * GLYPH_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DEPTH-1:0] rom_img;
    logic             pixel_q;

    for (genvar g = 0; g < NUM_GLYPHS; g++) begin : g_glyph
        for (genvar r = 0; r < GLYPH_H; r++) begin : g_row
            for (genvar c = 0; c < GLYPH_W; c++) begin : g_col
                assign rom_img[g*GLYPH_W*GLYPH_H + r*GLYPH_W + c] = glyph_px(g, r, c);
            end
        end
    end

    // Guard keeps non-power-of-two depths from reading past the image.
    always_ff @(posedge clk) begin
        pixel_q <= (addr <= LAST_ADDR) ? rom_img[addr] : 1'b0;
    end

    assign pixel_out = pixel_q;

endmodule

// File: rtl/note_sprite_renderer.sv
// -----------------------------------------------------------------------------
// note_sprite_renderer
// Draws one music-note glyph at a per-frame latched position, with optional
// 180-degree rotation and 2x scaling, and returns a one-bit ink flag per
// scanned pixel two clocks after the pixel's coordinates are presented.
//   clk, reset            pixel clock, async active-high reset
//   frame_start           loads the shadow sprite registers from spr_*
//   de, hcount, vcount    scan position (valid when de=1)
//   spr_en/x/y/glyph/flip/scale2x   staged sprite attributes
//   pixel_valid           de delayed 2 cycles
//   hit                   pixel inside sprite box, delayed 2 cycles
//   pixel_on              glyph ink at this pixel, delayed 2 cycles
// -----------------------------------------------------------------------------
module note_sprite_renderer
    import note_sprite_pkg::*;
#(
    parameter int GLYPH_W    = 20,
    parameter int GLYPH_H    = 30,
    parameter int NUM_GLYPHS = 4,
    parameter int COORD_W    = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          de,
    input  logic [COORD_W-1:0]            hcount,
    input  logic [COORD_W-1:0]            vcount,
    input  logic                          spr_en,
    input  logic [COORD_W-1:0]            spr_x,
    input  logic [COORD_W-1:0]            spr_y,
    input  logic [$clog2(NUM_GLYPHS)-1:0] spr_glyph,
    input  logic                          spr_flip,
    input  logic                          spr_scale2x,
    output logic                          pixel_valid,
    output logic                          hit,
    output logic                          pixel_on
);

    localparam int GSEL_W = $clog2(NUM_GLYPHS);
    localparam int ADDR_W = $clog2(NUM_GLYPHS * GLYPH_W * GLYPH_H);
    localparam int EXT_W  = COORD_W + 2;

    // Shadow sprite registers
    logic               en_q,    en_d;
    logic [COORD_W-1:0] x_q,     x_d;
    logic [COORD_W-1:0] y_q,     y_d;
    logic [GSEL_W-1:0]  glyph_q, glyph_d;
    logic               flip_q,  flip_d;
    logic               scale_q, scale_d;

    // Pipeline
    logic               hit1_q,   hit1_d;
    logic               valid1_q, valid1_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic               hit2_q;
    logic               valid2_q;
    logic               rom_bit;

    always_comb begin
        en_d    = en_q;
        x_d     = x_q;
        y_d     = y_q;
        glyph_d = glyph_q;
        flip_d  = flip_q;
        scale_d = scale_q;
        if (frame_start) begin
            en_d    = spr_en;
            x_d     = spr_x;
            y_d     = spr_y;
            glyph_d = spr_glyph;
            flip_d  = spr_flip;
            scale_d = spr_scale2x;
        end
    end

    // Stage 1: box test and ROM address, using the shadow values held before
    // this edge. The box end is computed two bits wider than the screen so a
    // sprite near the right/bottom edge is clipped instead of wrapping to 0.
    logic [EXT_W-1:0]   h_ext, v_ext, x_ext, y_ext, x_end, y_end;
    logic               in_box;
    logic [COORD_W-1:0] dx, dy;
    logic [31:0]        col, row, col_f, row_f;

    always_comb begin
        h_ext  = EXT_W'(hcount);
        v_ext  = EXT_W'(vcount);
        x_ext  = EXT_W'(x_q);
        y_ext  = EXT_W'(y_q);
        x_end  = x_ext + (scale_q ? EXT_W'(2 * GLYPH_W) : EXT_W'(GLYPH_W));
        y_end  = y_ext + (scale_q ? EXT_W'(2 * GLYPH_H) : EXT_W'(GLYPH_H));
        in_box = (h_ext >= x_ext) && (h_ext < x_end) &&
                 (v_ext >= y_ext) && (v_ext < y_end);

        // Only meaningful inside the box; outside, the address is don't-care.
        dx    = hcount - x_q;
        dy    = vcount - y_q;
        col   = 32'(dx) >> scale_q;
        row   = 32'(dy) >> scale_q;
        col_f = flip_q ? 32'(GLYPH_W - 1) - col : col;
        row_f = flip_q ? 32'(GLYPH_H - 1) - row : row;
        addr_d = ADDR_W'(32'(glyph_q) * 32'(GLYPH_W * GLYPH_H) +
                         row_f * 32'(GLYPH_W) + col_f);

        hit1_d   = de & en_q & in_box;
        valid1_d = de;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            glyph_q  <= '0;
            flip_q   <= 1'b0;
            scale_q  <= 1'b0;
            hit1_q   <= 1'b0;
            valid1_q <= 1'b0;
            addr_q   <= '0;
            hit2_q   <= 1'b0;
            valid2_q <= 1'b0;
        end else begin
            en_q     <= en_d;
            x_q      <= x_d;
            y_q      <= y_d;
            glyph_q  <= glyph_d;
            flip_q   <= flip_d;
            scale_q  <= scale_d;
            hit1_q   <= hit1_d;
            valid1_q <= valid1_d;
            addr_q   <= addr_d;
            hit2_q   <= hit1_q;
            valid2_q <= valid1_q;
        end
    end

    // Stage 2: ROM read aligned with hit2_q/valid2_q.
    note_glyph_rom #(
        .GLYPH_W    (GLYPH_W),
        .GLYPH_H    (GLYPH_H),
        .NUM_GLYPHS (NUM_GLYPHS),
        .ADDR_W     (ADDR_W)
    ) u_rom (
        .clk       (clk),
        .addr      (addr_q),
        .pixel_out (rom_bit)
    );

    // The ROM register has no reset; gating by hit2_q keeps pixel_on at 0
    // through reset and outside the sprite.
    assign pixel_on    = hit2_q & rom_bit;
    assign hit         = hit2_q;
    assign pixel_valid = valid2_q;

endmodule

// File: tb/tb_note_sprite_renderer.sv
module tb_note_sprite_renderer;
    import note_sprite_pkg::*;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          de = 1'b0;
    logic [CW-1:0] hcount = '0;
    logic [CW-1:0] vcount = '0;
    logic          spr_en = 1'b0;
    logic [CW-1:0] spr_x = '0;
    logic [CW-1:0] spr_y = '0;
    logic [1:0]    spr_glyph = '0;
    logic          spr_flip = 1'b0;
    logic          spr_scale2x = 1'b0;
    logic          pixel_valid, hit, pixel_on;

    note_sprite_renderer #(
        .GLYPH_W(20), .GLYPH_H(30), .NUM_GLYPHS(4), .COORD_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .de(de),
        .hcount(hcount), .vcount(vcount), .spr_en(spr_en), .spr_x(spr_x),
        .spr_y(spr_y), .spr_glyph(spr_glyph), .spr_flip(spr_flip),
        .spr_scale2x(spr_scale2x), .pixel_valid(pixel_valid), .hit(hit),
        .pixel_on(pixel_on)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    bit    exp_hit_q[$];
    bit    exp_on_q[$];
    int    exp_cyc_q[$];
    string exp_name_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per valid output pixel.
    always @(negedge clk) begin : mon
        string nm;
        bit    eh, eo;
        int    ec;
        if (!reset) begin
            if (pixel_valid) begin
                if (exp_hit_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    nm = exp_name_q.pop_front();
                    eh = exp_hit_q.pop_front();
                    eo = exp_on_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check({nm, "_hit"}, int'(hit), int'(eh));
                    check({nm, "_on"}, int'(pixel_on), int'(eo));
                    check({nm, "_latency"}, cyc - ec, 2);
                end
            end else begin
                check("idle_quiet", int'(hit | pixel_on), 0);
            end
        end
    end

    task automatic pix(input int h, input int v, input bit eh, input bit eo, input string nm);
        @(posedge clk); #1;
        de = 1'b1; frame_start = 1'b0;
        hcount = CW'(h); vcount = CW'(v);
        exp_hit_q.push_back(eh); exp_on_q.push_back(eo);
        exp_cyc_q.push_back(cyc); exp_name_q.push_back(nm);
    endtask

    task automatic pix_fs(input int h, input int v, input int newx, input bit eh, input bit eo,
                          input string nm);
        @(posedge clk); #1;
        de = 1'b1; frame_start = 1'b1; spr_x = CW'(newx);
        hcount = CW'(h); vcount = CW'(v);
        exp_hit_q.push_back(eh); exp_on_q.push_back(eo);
        exp_cyc_q.push_back(cyc); exp_name_q.push_back(nm);
    endtask

    task automatic load(input bit en, input int x, input int y, input int g, input bit fl,
                        input bit sc);
        @(posedge clk); #1;
        de = 1'b0; frame_start = 1'b1;
        spr_en = en; spr_x = CW'(x); spr_y = CW'(y);
        spr_glyph = 2'(g); spr_flip = fl; spr_scale2x = sc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            de = 1'b0; frame_start = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(pixel_valid), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_on", int'(pixel_on), 0);
        reset = 1'b0;

        // Quarter note at (100,50)
        load(1'b1, 100, 50, GLYPH_QUARTER, 1'b0, 1'b0);
        pix(100, 57, 1'b1, 1'b1, "q_stem");
        pix(116, 60, 1'b1, 1'b0, "q_right_of_head");
        pix(120, 60, 1'b0, 1'b0, "q_past_right");
        pix(99, 57, 1'b0, 1'b0, "q_left_of_box");
        pix(100, 49, 1'b0, 1'b0, "q_above_box");
        pix(105, 60, 1'b1, 1'b1, "q_head");
        pix(119, 79, 1'b1, 1'b0, "q_corner");
        pix(100, 80, 1'b0, 1'b0, "q_below_box");
        idle(1);

        // Reset while the pipeline holds inked pixels
        pix(100, 57, 1'b1, 1'b1, "pre_rst_a");
        pix(100, 58, 1'b1, 1'b1, "pre_rst_b");
        @(posedge clk); #1;
        reset = 1'b1; de = 1'b0;
        #1;
        check("midrst_valid", int'(pixel_valid), 0);
        check("midrst_hit", int'(hit), 0);
        check("midrst_on", int'(pixel_on), 0);
        exp_hit_q.delete(); exp_on_q.delete(); exp_cyc_q.delete(); exp_name_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;

        // No frame_start after reset: sprite disabled
        pix(100, 57, 1'b0, 1'b0, "norld_stem");
        pix(105, 60, 1'b0, 1'b0, "norld_head");
        pix(110, 70, 1'b0, 1'b0, "norld_mid");
        idle(1);

        // Flipped quarter
        load(1'b1, 100, 50, GLYPH_QUARTER, 1'b1, 1'b0);
        pix(119, 50, 1'b1, 1'b1, "flip_stem_top");
        pix(118, 72, 1'b1, 1'b1, "flip_stem_head");
        pix(100, 57, 1'b1, 1'b0, "flip_old_stem");
        pix(119, 79, 1'b1, 1'b0, "flip_corner");

        // Half and whole notes
        load(1'b1, 100, 50, GLYPH_HALF, 1'b0, 1'b0);
        pix(108, 60, 1'b1, 1'b0, "half_hollow");
        pix(102, 60, 1'b1, 1'b1, "half_rim");
        load(1'b1, 100, 50, GLYPH_WHOLE, 1'b0, 1'b0);
        pix(100, 75, 1'b1, 1'b0, "whole_nostem");
        pix(101, 60, 1'b1, 1'b1, "whole_rim");
        pix(108, 60, 1'b1, 1'b0, "whole_hollow");

        // Eighth note flag
        load(1'b1, 100, 50, GLYPH_EIGHTH, 1'b0, 1'b0);
        pix(104, 72, 1'b1, 1'b1, "eighth_flag_a");
        pix(105, 72, 1'b1, 1'b1, "eighth_flag_b");
        pix(106, 72, 1'b1, 1'b0, "eighth_flag_gap");

        // 2x scaling at origin
        load(1'b1, 0, 0, GLYPH_QUARTER, 1'b0, 1'b1);
        pix(1, 15, 1'b1, 1'b1, "s2_stem_a");
        pix(0, 14, 1'b1, 1'b1, "s2_stem_b");
        pix(1, 13, 1'b1, 1'b0, "s2_above_stem");
        pix(39, 59, 1'b1, 1'b0, "s2_last_in");
        pix(40, 59, 1'b0, 1'b0, "s2_past_right");
        pix(39, 60, 1'b0, 1'b0, "s2_past_bottom");

        // Right-edge clipping
        load(1'b1, 1015, 50, GLYPH_QUARTER, 1'b0, 1'b0);
        pix(0, 60, 1'b0, 1'b0, "clip_nowrap");
        pix(1020, 60, 1'b1, 1'b1, "clip_head");
        pix(1023, 60, 1'b1, 1'b1, "clip_edge");
        pix(1015, 57, 1'b1, 1'b1, "clip_stem");

        // Staged x change without frame_start is ignored
        spr_x = CW'(100);
        pix(1020, 60, 1'b1, 1'b1, "stage_hold_old");
        pix(100, 57, 1'b0, 1'b0, "stage_hold_new");

        // frame_start on the same edge as a pixel: that pixel sees the old x
        pix_fs(1015, 57, 100, 1'b1, 1'b1, "fs_same_edge");
        pix(100, 57, 1'b1, 1'b1, "fs_new_pos");
        pix(1015, 57, 1'b0, 1'b0, "fs_old_pos");

        // Disabled sprite
        load(1'b0, 100, 50, GLYPH_QUARTER, 1'b0, 1'b0);
        pix(100, 57, 1'b0, 1'b0, "disabled");
        idle(1);

        begin : drain
            int waitc;
            waitc = 0;
            while (exp_hit_q.size() > 0 && waitc < 20) begin
                @(posedge clk);
                waitc++;
            end
        end
        if (exp_hit_q.size() != 0) check("drain_timeout", exp_hit_q.size(), 0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
